// File: rtl/booth_div_pkg.sv
// Shared types and constants for the signed sequential divider.
// Widths are fixed here; the datapath modules import them.
package booth_div_pkg;

   localparam int N     = 8;
   localparam int DVD_W = 2 * N;
   localparam int CNT_W = $clog2(DVD_W);

   localparam logic [N-1:0] QMAX = {1'b0, {(N-1){1'b1}}};
   localparam logic [N-1:0] QMIN = {1'b1, {(N-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      FIX  = 2'd2
   } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: N+1-bit trial subtract, keep result if non-negative.
// Purely combinational, zero latency; no flow control.
module div_step
   import booth_div_pkg::*;
(
   input  logic [N-1:0] i_p,
   input  logic         i_bit,
   input  logic [N-1:0] i_dvs_mag,
   output logic [N-1:0] o_p,
   output logic         o_qbit
);

   logic [N:0] w_shift;
   logic [N:0] w_trial;

   assign w_shift = {i_p, i_bit};
   assign w_trial = w_shift - {1'b0, i_dvs_mag};

   // The sign bit of the trial result decides restore versus keep.
   assign o_qbit = ~w_trial[N];
   assign o_p    = o_qbit ? w_trial[N-1:0] : w_shift[N-1:0];

endmodule

// File: rtl/booth_divider.sv
// Signed 2N/N divider, one restoring step per clock plus a sign fix-up cycle (2N+1 edges; 1 on divide-by-zero).
// No backpressure: start is taken only in IDLE and ignored while busy.
module booth_divider
   import booth_div_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [DVD_W-1:0] dvd,
   input  logic [N-1:0]     dvs,
   output logic [N-1:0]     quot,
   output logic [N-1:0]     rem,
   output logic             busy,
   output logic             done,
   output logic             ovf,
   output logic             dbz
);

   state_t             r_state;
   state_t             w_state_nxt;

   logic               r_sd;
   logic               r_sv;
   logic               r_dbz_path;
   logic [N-1:0]       r_dvs_mag;
   // The partial remainder stays below |dvs| <= 2^(N-1), so the top bit of
   // the N+1-bit value is always zero and only N bits are kept.
   logic [N-1:0]       r_p;
   logic [DVD_W-1:0]   r_qm;
   logic [CNT_W-1:0]   r_cnt;

   logic [N-1:0]       r_quot;
   logic [N-1:0]       r_rem;
   logic               r_done;
   logic               r_ovf;
   logic               r_dbz;

   logic [DVD_W-1:0]   w_dvd_mag;
   logic [N-1:0]       w_dvs_mag;
   logic [N-1:0]       w_p_nxt;
   logic               w_qbit;
   logic               w_neg;
   logic               w_range_ovf;
   logic [N-1:0]       w_quot;
   logic [N-1:0]       w_rem;
   logic               w_ovf;

   assign w_dvd_mag = dvd[DVD_W-1] ? -dvd : dvd;
   assign w_dvs_mag = dvs[N-1]     ? -dvs : dvs;

   div_step u_step (
      .i_p       (r_p),
      .i_bit     (r_qm[DVD_W-1]),
      .i_dvs_mag (r_dvs_mag),
      .o_p       (w_p_nxt),
      .o_qbit    (w_qbit)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: if (start) w_state_nxt = (dvs == '0) ? FIX : BUSY;
         BUSY: if (r_cnt == CNT_W'(DVD_W - 1)) w_state_nxt = FIX;
         FIX:  w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Sign fix-up: magnitudes are in r_qm/r_p, signs in r_sd/r_sv.
   assign w_neg       = r_sd ^ r_sv;
   assign w_range_ovf = w_neg ? (r_qm > {{N{1'b0}}, QMIN})
                              : (r_qm > {{N{1'b0}}, QMAX});

   always_comb begin
      w_quot = '0;
      w_rem  = '0;
      w_ovf  = 1'b0;
      if (r_dbz_path) begin
         w_quot = r_sd ? QMIN : QMAX;
      end else if (w_range_ovf) begin
         w_ovf  = 1'b1;
         w_quot = w_neg ? QMIN : QMAX;
      end else begin
         w_quot = w_neg ? -r_qm[N-1:0] : r_qm[N-1:0];
         w_rem  = r_sd  ? -r_p         : r_p;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sd       <= 1'b0;
         r_sv       <= 1'b0;
         r_dbz_path <= 1'b0;
         r_dvs_mag  <= '0;
         r_p        <= '0;
         r_qm       <= '0;
         r_cnt      <= '0;
         r_quot     <= '0;
         r_rem      <= '0;
         r_done     <= 1'b0;
         r_ovf      <= 1'b0;
         r_dbz      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_sd       <= dvd[DVD_W-1];
                  r_sv       <= dvs[N-1];
                  r_dvs_mag  <= w_dvs_mag;
                  r_p        <= '0;
                  r_qm       <= w_dvd_mag;
                  r_cnt      <= '0;
                  r_dbz_path <= (dvs == '0);
               end
            end
            BUSY: begin
               r_p   <= w_p_nxt;
               r_qm  <= {r_qm[DVD_W-2:0], w_qbit};
               r_cnt <= r_cnt + CNT_W'(1);
            end
            FIX: begin
               r_quot <= w_quot;
               r_rem  <= w_rem;
               r_ovf  <= w_ovf;
               r_dbz  <= r_dbz_path;
               r_done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign quot = r_quot;
   assign rem  = r_rem;
   assign busy = (r_state != IDLE);
   assign done = r_done;
   assign ovf  = r_ovf;
   assign dbz  = r_dbz;

endmodule
